// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multicycle CPU control path
package cpu_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] WADR_RT  = 2'd0;
    localparam logic [1:0] WADR_RD  = 2'd1;
    localparam logic [1:0] WADR_R31 = 2'd2;

    localparam logic [1:0] DIN_ALU = 2'd0;
    localparam logic [1:0] DIN_MEM = 2'd1;
    localparam logic [1:0] DIN_PC  = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - opcode/funct to ALU operation, operand and extender selects
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       sel_b,
    output logic       sgn,
    output logic       legal
);

    always_comb begin
        alucontrol = ALU_ADD;
        sel_b      = 1'b0;
        sgn        = 1'b0;
        legal      = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_SLT:  alucontrol = ALU_SLT;
                    FN_JR:   alucontrol = ALU_ADD;
                    default: legal      = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                sel_b = 1'b1;
                sgn   = 1'b1;
            end
            OP_XORI: begin
                sel_b      = 1'b1;
                alucontrol = ALU_XOR;
            end
            OP_BNE:       alucontrol = ALU_SUB;
            OP_J, OP_JAL: alucontrol = ALU_ADD;
            default:      legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       im_req,
    output logic       ir_wen,
    output logic       pc_wen,
    output logic [1:0] sel_pc,
    output logic       sel_b,
    output logic       sgn,
    output logic [2:0] alucontrol,
    output logic       dm_req,
    output logic       dm_wen,
    output logic       rf_wen,
    output logic [1:0] rf_selwadr,
    output logic [1:0] rf_seldin,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    logic [2:0] dec_alu;
    logic       dec_sel_b;
    logic       dec_sgn;
    logic       dec_legal;
    logic       is_rtype;
    logic       is_jr;

    alu_decoder u_alu_decoder (
        .opcode     (opcode),
        .funct      (funct),
        .alucontrol (dec_alu),
        .sel_b      (dec_sel_b),
        .sgn        (dec_sgn),
        .legal      (dec_legal)
    );

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!dec_legal)                                  state_d = ST_HALT;
                else if (opcode == OP_J || opcode == OP_JAL || is_jr) state_d = ST_FETCH;
                else                                             state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = ST_MEM;
                else if (opcode == OP_BNE)              state_d = ST_FETCH;
                else                                    state_d = ST_WB;
            end
            ST_MEM:    if (mem_ready) state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_HALT) illegal_q <= 1'b1;
        end
    end

    // Reset overrides everything so an abandoned instruction never writes state.
    always_comb begin
        im_req     = 1'b0;
        ir_wen     = 1'b0;
        pc_wen     = 1'b0;
        sel_pc     = PC_PLUS4;
        sel_b      = 1'b0;
        sgn        = 1'b0;
        alucontrol = ALU_ADD;
        dm_req     = 1'b0;
        dm_wen     = 1'b0;
        rf_wen     = 1'b0;
        rf_selwadr = WADR_RT;
        rf_seldin  = DIN_ALU;
        illegal    = 1'b0;
        state      = state_q;
        if (reset) begin
            state = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    im_req = 1'b1;
                    ir_wen = mem_ready;
                    pc_wen = mem_ready;
                end
                ST_DECODE: begin
                    if (dec_legal && (opcode == OP_J || opcode == OP_JAL)) begin
                        pc_wen = 1'b1;
                        sel_pc = PC_JUMP;
                    end
                    if (dec_legal && opcode == OP_JAL) begin
                        rf_wen     = 1'b1;
                        rf_selwadr = WADR_R31;
                        rf_seldin  = DIN_PC;
                    end
                    if (is_jr) begin
                        pc_wen = 1'b1;
                        sel_pc = PC_REG;
                    end
                end
                ST_EXEC, ST_MEM, ST_WB: begin
                    sel_b      = dec_sel_b;
                    sgn        = dec_sgn;
                    alucontrol = dec_alu;
                    if (state_q == ST_EXEC && opcode == OP_BNE) begin
                        pc_wen = ~alu_zero;
                        sel_pc = PC_BRANCH;
                    end
                    if (state_q == ST_MEM) begin
                        dm_req = 1'b1;
                        dm_wen = (opcode == OP_SW);
                    end
                    if (state_q == ST_WB) begin
                        rf_wen     = 1'b1;
                        rf_selwadr = is_rtype ? WADR_RD : WADR_RT;
                        rf_seldin  = (opcode == OP_LW) ? DIN_MEM : DIN_ALU;
                    end
                end
                ST_HALT:  illegal = illegal_q;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       im_req, ir_wen, pc_wen, sel_b, sgn, dm_req, dm_wen, rf_wen, illegal;
    logic [1:0] sel_pc, rf_selwadr, rf_seldin;
    logic [2:0] alucontrol, state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .im_req     (im_req),
        .ir_wen     (ir_wen),
        .pc_wen     (pc_wen),
        .sel_pc     (sel_pc),
        .sel_b      (sel_b),
        .sgn        (sgn),
        .alucontrol (alucontrol),
        .dm_req     (dm_req),
        .dm_wen     (dm_wen),
        .rf_wen     (rf_wen),
        .rf_selwadr (rf_selwadr),
        .rf_seldin  (rf_seldin),
        .illegal    (illegal),
        .state      (state)
    );

    // Control word: im ir pc sel_pc(2) sel_b sgn alu(3) dmr dmw rfw wadr(2) din(2) ill state(3)
    logic [20:0] ctrl;
    assign ctrl = {im_req, ir_wen, pc_wen, sel_pc, sel_b, sgn, alucontrol,
                   dm_req, dm_wen, rf_wen, rf_selwadr, rf_seldin, illegal, state};

    function automatic logic [20:0] w(input int im, ir, pcw, spc, sb, sg, alu,
                                      dmr, dmw, rfw, wadr, din, ill, st);
        logic [20:0] r;
        r = {im[0], ir[0], pcw[0], spc[1:0], sb[0], sg[0], alu[2:0],
             dmr[0], dmw[0], rfw[0], wadr[1:0], din[1:0], ill[0], st[2:0]};
        return r;
    endfunction

    task automatic cyc(input string tag, input logic [20:0] expected);
        @(negedge clk);
        vectors++;
        assert (ctrl === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%06h expected=%06h", tag, ctrl, expected);
        end
        @(posedge clk);
        #1;
    endtask

    logic [20:0] fetch_go, fetch_wait, decode_idle;

    initial begin
        fetch_go    = w(1,1,1,0, 0,0,0, 0,0,0,0,0, 0,0);
        fetch_wait  = w(1,0,0,0, 0,0,0, 0,0,0,0,0, 0,0);
        decode_idle = w(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,1);

        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0;
        @(posedge clk); #1;
        cyc("reset_forced_zero", w(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        reset = 1'b0;

        // ADD: 4 cycles
        cyc("add_fetch",  fetch_go);
        cyc("add_decode", decode_idle);
        cyc("add_exec",   w(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,2));
        cyc("add_wb",     w(0,0,0,0, 0,0,0, 0,0,1,1,0, 0,4));

        // LW with two MEM wait cycles: 7 cycles
        opcode = 6'h23;
        cyc("lw_fetch",  fetch_go);
        cyc("lw_decode", decode_idle);
        cyc("lw_exec",   w(0,0,0,0, 1,1,0, 0,0,0,0,0, 0,2));
        mem_ready = 1'b0;
        cyc("lw_mem_wait1", w(0,0,0,0, 1,1,0, 1,0,0,0,0, 0,3));
        cyc("lw_mem_wait2", w(0,0,0,0, 1,1,0, 1,0,0,0,0, 0,3));
        mem_ready = 1'b1;
        cyc("lw_mem_done",  w(0,0,0,0, 1,1,0, 1,0,0,0,0, 0,3));
        cyc("lw_wb",        w(0,0,0,0, 1,1,0, 0,0,1,0,1, 0,4));

        // BNE taken, preceded by a fetch wait
        opcode = 6'h05; alu_zero = 1'b0; mem_ready = 1'b0;
        cyc("bne_fetch_wait", fetch_wait);
        mem_ready = 1'b1;
        cyc("bne_fetch",  fetch_go);
        mem_ready = 1'b0;
        cyc("bne_decode_ready_ignored", decode_idle);
        cyc("bne_taken_exec", w(0,0,1,1, 0,0,1, 0,0,0,0,0, 0,2));
        mem_ready = 1'b1;

        // BNE not taken
        alu_zero = 1'b1;
        cyc("bne_nt_fetch",  fetch_go);
        cyc("bne_nt_decode", decode_idle);
        cyc("bne_nt_exec",   w(0,0,0,1, 0,0,1, 0,0,0,0,0, 0,2));
        alu_zero = 1'b0;

        // JAL then JR
        opcode = 6'h03;
        cyc("jal_fetch",  fetch_go);
        cyc("jal_decode", w(0,0,1,2, 0,0,0, 0,0,1,2,2, 0,1));
        opcode = 6'h00; funct = 6'h08;
        cyc("jr_fetch",   fetch_go);
        cyc("jr_decode",  w(0,0,1,3, 0,0,0, 0,0,0,0,0, 0,1));

        // XORI
        opcode = 6'h0E;
        cyc("xori_fetch",  fetch_go);
        cyc("xori_decode", decode_idle);
        cyc("xori_exec",   w(0,0,0,0, 1,0,2, 0,0,0,0,0, 0,2));
        cyc("xori_wb",     w(0,0,0,0, 1,0,2, 0,0,1,0,0, 0,4));

        // SLT
        opcode = 6'h00; funct = 6'h2A;
        cyc("slt_fetch",  fetch_go);
        cyc("slt_decode", decode_idle);
        cyc("slt_exec",   w(0,0,0,0, 0,0,3, 0,0,0,0,0, 0,2));
        cyc("slt_wb",     w(0,0,0,0, 0,0,3, 0,0,1,1,0, 0,4));

        // SW complete: 4 cycles
        opcode = 6'h2B;
        cyc("sw_fetch",  fetch_go);
        cyc("sw_decode", decode_idle);
        cyc("sw_exec",   w(0,0,0,0, 1,1,0, 0,0,0,0,0, 0,2));
        cyc("sw_mem",    w(0,0,0,0, 1,1,0, 1,1,0,0,0, 0,3));

        // SW abandoned by reset during MEM wait
        cyc("sw2_fetch",  fetch_go);
        cyc("sw2_decode", decode_idle);
        cyc("sw2_exec",   w(0,0,0,0, 1,1,0, 0,0,0,0,0, 0,2));
        mem_ready = 1'b0;
        cyc("sw2_mem_wait", w(0,0,0,0, 1,1,0, 1,1,0,0,0, 0,3));
        reset = 1'b1;
        cyc("sw2_reset_no_wen", w(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        reset = 1'b0; mem_ready = 1'b1;
        cyc("sw2_after_reset_fetch", fetch_go);

        // Illegal opcode halts until reset
        opcode = 6'h3F;
        cyc("ill_decode", decode_idle);
        for (int i = 0; i < 11; i++) begin
            mem_ready = i[0];
            cyc("ill_halt", w(0,0,0,0, 0,0,0, 0,0,0,0,0, 1,5));
        end
        reset = 1'b1; mem_ready = 1'b1;
        cyc("ill_reset", w(0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0));
        reset = 1'b0; opcode = 6'h00; funct = 6'h20;
        cyc("ill_recover_fetch", fetch_go);

        // Unsupported funct also halts
        funct = 6'h21;
        cyc("badfn_decode", decode_idle);
        cyc("badfn_halt",   w(0,0,0,0, 0,0,0, 0,0,0,0,0, 1,5));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
